msk_share_recombiner: RTL and testbench
=======================================

// Module: msk_share_recombiner
// PURPOSE
//   Consumer end of a d-share masked datapath such as the HPC2 AND gadgets: it accepts one
//   W-bit d-share sharing and reconstructs the unmasked value.
//   Recombination is share-serial. The accumulator XORs in exactly one registered share per
//   cycle, so no combinational cone ever sees two shares at once (glitch-robust unmasking).
//   Each consumed share register is zeroized as it is used.
//   Sits at the boundary between the masked core and unmasked output logic.
// PARAMETERS
//   d   2   number of shares, legal range >=1
//   W   32  width of one share and of the unmasked output
// PORTS
//   clk        in   1    clock, all state on rising edge
//   rst_n      in   1    asynchronous active-low reset
//   flush      in   1    synchronous abort; clears all state and returns to IDLE
//   in_valid   in   1    in_shares carries a sharing
//   in_ready   out  1    recombiner accepts the sharing this cycle
//   in_shares  in   d*W  share i at bits [i*W +: W]
//   out_valid  out  1    out_data holds the recombined value
//   out_ready  in   1    downstream consumes out_data
//   out_data   out  W    XOR of all d shares; 0 whenever out_valid=0
//   busy       out  1    state != IDLE
// BEHAVIOUR
//   Reset: rst_n=0 asynchronously clears all registers and sets state=IDLE.
//     - Cleared registers: share regs, accumulator, counter.
//     - Outputs: in_ready=1, out_valid=0, out_data=0, busy=0.
//   Accept: an accept occurs when in_valid & in_ready.
//     - in_ready = !flush & (IDLE | (OUT & out_ready)).
//   FSM states: IDLE, ACC, OUT. cnt is log2(d)-bit, min 1 bit.
//   IDLE, on accept:
//     - sreg <= in_shares, acc <= 0, cnt <= 0.
//     - Next state is ACC.
//   ACC, every cycle:
//     - acc <= acc ^ sreg[cnt], sreg[cnt] <= 0, cnt <= cnt+1.
//     - When cnt==d-1, next state is OUT and cnt <= 0.
//   OUT:
//     - out_valid=1, out_data=acc.
//     - out_ready=0: hold acc and stay in OUT; data stays stable.
//     - out_ready=1 without accept: acc <= 0, next state IDLE.
//     - out_ready=1 with accept (back-to-back): load new sreg, acc <= 0, cnt <= 0, next state ACC.
//   Latency:
//     - Accept at edge k gives out_valid=1 in the cycle after edge k+d.
//     - Sustained throughput is 1 sharing per d+1 cycles.
//     - For d=1, ACC lasts exactly one cycle.
//   out_data is driven by an AND of acc with the registered OUT-state flag, so no partial
//   sums ever appear on the port.
//   flush=1, from any state, at the next edge:
//     - sreg=0, acc=0, cnt=0, state=IDLE.
//     - No accept that cycle.
//     - Any pending output is dropped; out_valid falls after that edge.
//   flush outranks all other events. Async reset outranks flush.
//   Reset mid-ACC: shares are discarded and cleared; no output is ever produced for that sharing.
//   in_shares is ignored outside an accept cycle. Shares of different sharings never meet.
// TESTING
//   1. d=2, W=32: accept {0x0F0F0F0F, 0xA5A5A5A5} with out_ready=1.
//      -> out_valid after 2 cycles, out_data=0xAAAAAAAA, then IDLE.
//   2. d=3: shares 0x1,0x2,0x4, out_ready=0 for 5 cycles then 1.
//      -> out_data=0x7 held stable while stalled; in_ready=0 throughout the stall.
//   3. Back-to-back, d=2: second sharing accepted in the OUT cycle with out_ready=1.
//      -> outputs 3 cycles apart; both values correct.
//   4. flush asserted in ACC (cnt=1, d=3).
//      -> no out_valid; sreg, acc and out_data are all 0 the next cycle; in_ready=1.
//   5. rst_n pulsed low between clock edges during ACC.
//      -> outputs reset immediately; post-reset sharing {0xFFFF0000, 0x0000FFFF} yields 0xFFFFFFFF.
//   6. Zeroization: after each ACC cycle, probe sreg.
//      -> consumed share is 0; sreg is all-zero when OUT is entered.

Source files
------------

// File: rtl/msk_share_recombiner.sv
// Share-serial unmasking of a d-share sharing: one registered share per cycle
// is folded into the accumulator and zeroized as it is consumed.
module msk_share_recombiner #(
    parameter int d = 2,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [d*W-1:0] in_shares,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           busy
);

    localparam int CW = (d > 1) ? $clog2(d) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(d - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    state_t         state_q;
    logic           out_q;
    logic [W-1:0]   acc_q;
    logic [W-1:0]   acc_d;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   sreg_q [d];
    logic           accept;

    assign in_ready  = !flush & ((state_q == IDLE) | (out_q & out_ready));
    assign accept    = in_valid & in_ready;
    assign acc_d     = acc_q ^ sreg_q[cnt_q];
    assign out_valid = out_q;
    assign busy      = (state_q != IDLE);

    // Gate with the registered OUT flag so partial sums never reach the port.
    assign out_data  = acc_q & {W{out_q}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < d; i++) sreg_q[i] <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            out_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < d; i++) sreg_q[i] <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        for (int i = 0; i < d; i++)
                            sreg_q[i] <= in_shares[i*W +: W];
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    acc_q         <= acc_d;
                    sreg_q[cnt_q] <= '0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= OUT;
                        out_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        acc_q <= '0;
                        out_q <= 1'b0;
                        cnt_q <= '0;
                        if (accept) begin
                            for (int i = 0; i < d; i++)
                                sreg_q[i] <= in_shares[i*W +: W];
                            state_q <= ACC;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msk_share_recombiner.sv
// Bench for msk_share_recombiner: d=2 and d=3 instances, directed vectors,
// corner sequences and a transaction-level random model.
module tb_msk_share_recombiner;

    logic        clk;
    logic        rst_n;
    logic        fl   [2];
    logic        iv   [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        ordy [2];
    logic        bz   [2];
    logic [31:0] od   [2];
    logic [63:0] sh2;
    logic [95:0] sh3;

    int n_cmp;
    int n_bad;

    msk_share_recombiner #(.d(2), .W(32)) u2 (
        .clk(clk), .rst_n(rst_n), .flush(fl[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_shares(sh2),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .busy(bz[0])
    );

    msk_share_recombiner #(.d(3), .W(32)) u3 (
        .clk(clk), .rst_n(rst_n), .flush(fl[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_shares(sh3),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] s;
        logic [31:0] e;
        int          stall;
    } vec_t;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic set_sh(int u, logic [95:0] s);
        if (u == 0) sh2 = s[63:0];
        else sh3 = s;
    endtask

    // Starts just after a rising edge with the unit idle; ends likewise.
    task automatic xfer(int u, logic [95:0] s, logic [31:0] e,
                        int stall, string nm);
        int n;
        int dd;
        dd = (u == 0) ? 2 : 3;
        set_sh(u, s);
        iv[u]   = 1'b1;
        ordy[u] = (stall == 0);
        @(negedge clk);
        chk({nm, " in_ready idle"}, 32'(ir[u]), 32'd1);
        @(posedge clk);
        #1;
        iv[u] = 1'b0;
        set_sh(u, {$urandom, $urandom, $urandom});
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (ov[u]) break;
            n++;
        end
        chk({nm, " latency"}, n, dd);
        chk({nm, " data"}, od[u], e);
        for (int i = 0; i < stall; i++) begin
            chk({nm, " stall valid"}, 32'(ov[u]), 32'd1);
            chk({nm, " stall data"}, od[u], e);
            chk({nm, " stall in_ready"}, 32'(ir[u]), 32'd0);
            @(negedge clk);
        end
        ordy[u] = 1'b1;
        #1;
        chk({nm, " in_ready out"}, 32'(ir[u]), 32'd1);
        @(posedge clk);
        #1;
        ordy[u] = 1'b0;
        @(negedge clk);
        chk({nm, " valid drop"}, 32'(ov[u]), 32'd0);
        chk({nm, " data zero"}, od[u], 32'd0);
        chk({nm, " busy idle"}, 32'(bz[u]), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] xor_sh(logic [95:0] s, int dd);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < dd; i++) r ^= s[i*32 +: 32];
        return r;
    endfunction

    vec_t        tbl [5];
    int          n;
    int          bad;
    logic        bm   [2];
    logic [31:0] vm   [2];
    int          rdy  [2];
    logic        pend_acc [2];
    logic        pend_pop [2];
    logic [31:0] pend_val [2];
    logic        vexp;
    logic        irexp;
    int          cyc;

    initial begin
        tbl[0] = '{96'h00000004_00000002_00000001, 32'h00000007, 5};
        tbl[1] = '{96'h00000000_FFFFFFFF_FFFFFFFF, 32'h00000000, 0};
        tbl[2] = '{96'h00000000_00000000_12345678, 32'h12345678, 1};
        tbl[3] = '{96'hFFFFFFFF_0F0F0F0F_F0F0F0F0, 32'h00000000, 0};
        tbl[4] = '{96'hDEADBEEF_DEADBEEF_DEADBEEF, 32'hDEADBEEF, 2};

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        sh2 = '0;
        sh3 = '0;
        for (int u = 0; u < 2; u++) begin
            fl[u] = 1'b0;
            iv[u] = 1'b0;
            ordy[u] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset in_ready", 32'(ir[u]), 32'd1);
            chk("reset out_valid", 32'(ov[u]), 32'd0);
            chk("reset out_data", od[u], 32'd0);
            chk("reset busy", 32'(bz[u]), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        xfer(0, {32'h0, 32'hA5A5A5A5, 32'h0F0F0F0F}, 32'hAAAAAAAA, 0, "t1");

        for (int i = 0; i < 5; i++)
            xfer(1, tbl[i].s, tbl[i].e, tbl[i].stall, $sformatf("tbl%0d", i));

        // back-to-back on d=2
        sh2 = {32'h00000003, 32'h00000005};
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (ov[0]) break;
            n++;
        end
        chk("b2b first latency", n, 2);
        ordy[0] = 1'b1;
        iv[0] = 1'b1;
        sh2 = {32'hCAFE0000, 32'h0000BABE};
        #1;
        chk("b2b in_ready", 32'(ir[0]), 32'd1);
        chk("b2b first data", od[0], 32'h00000006);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        ordy[0] = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (ov[0]) break;
            n++;
        end
        chk("b2b gap", n + 1, 3);
        chk("b2b second data", od[0], 32'hCAFEBABE);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        @(negedge clk);
        chk("b2b drained", 32'(bz[0]), 32'd0);
        @(posedge clk);
        #1;

        // flush during ACC with cnt=1, d=3
        sh3 = {32'h33333333, 32'h22222222, 32'h11111111};
        iv[1] = 1'b1;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        @(posedge clk);
        #1;
        chk("flush setup cnt", 32'(u3.cnt_q), 32'd1);
        fl[1] = 1'b1;
        @(posedge clk);
        #1;
        fl[1] = 1'b0;
        @(negedge clk);
        chk("flush sreg", u3.sreg_q[0] | u3.sreg_q[1] | u3.sreg_q[2], 32'd0);
        chk("flush acc", u3.acc_q, 32'd0);
        chk("flush out_data", od[1], 32'd0);
        chk("flush in_ready", 32'(ir[1]), 32'd1);
        chk("flush busy", 32'(bz[1]), 32'd0);
        bad = 0;
        ordy[1] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (ov[1]) bad++;
        end
        ordy[1] = 1'b0;
        chk("flush no output", bad, 0);
        @(posedge clk);
        #1;

        // async reset pulse mid-ACC on d=2
        sh2 = {32'h89ABCDEF, 32'h01234567};
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst busy", 32'(bz[0]), 32'd0);
        chk("rst in_ready", 32'(ir[0]), 32'd1);
        chk("rst out_valid", 32'(ov[0]), 32'd0);
        chk("rst sreg", u2.sreg_q[0] | u2.sreg_q[1], 32'd0);
        chk("rst acc", u2.acc_q, 32'd0);
        rst_n = 1'b1;
        bad = 0;
        ordy[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (ov[0]) bad++;
        end
        ordy[0] = 1'b0;
        chk("rst no output", bad, 0);
        @(posedge clk);
        #1;
        xfer(0, {32'h0, 32'h0000FFFF, 32'hFFFF0000}, 32'hFFFFFFFF, 0, "t5");

        // zeroization trace on d=3
        sh3 = {32'h44444444, 32'h22222222, 32'h11111111};
        iv[1] = 1'b1;
        @(posedge clk);
        #1;
        iv[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("zero s0 after1", u3.sreg_q[0], 32'd0);
        chk("zero s1 after1", u3.sreg_q[1], 32'h22222222);
        chk("zero s2 after1", u3.sreg_q[2], 32'h44444444);
        @(negedge clk);
        chk("zero s1 after2", u3.sreg_q[1], 32'd0);
        chk("zero s2 after2", u3.sreg_q[2], 32'h44444444);
        @(negedge clk);
        chk("zero all at OUT", u3.sreg_q[0] | u3.sreg_q[1] | u3.sreg_q[2], 32'd0);
        chk("zero out_valid", 32'(ov[1]), 32'd1);
        chk("zero out_data", od[1], 32'h77777777);
        ordy[1] = 1'b1;
        @(posedge clk);
        #1;
        ordy[1] = 1'b0;

        // random traffic against a transaction-level model
        for (int u = 0; u < 2; u++) bm[u] = 1'b0;
        cyc = 0;
        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < 2; u++) begin
                iv[u]   = ($urandom_range(0, 9) < 6);
                ordy[u] = ($urandom_range(0, 9) < 6);
                fl[u]   = ($urandom_range(0, 24) == 0);
            end
            sh2 = {$urandom, $urandom};
            sh3 = {$urandom, $urandom, $urandom};
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                vexp  = bm[u] && (cyc >= rdy[u]);
                irexp = !fl[u] && (!bm[u] || (vexp && ordy[u]));
                chk($sformatf("rnd%0d u%0d in_ready", c, u), 32'(ir[u]), 32'(irexp));
                chk($sformatf("rnd%0d u%0d valid", c, u), 32'(ov[u]), 32'(vexp));
                chk($sformatf("rnd%0d u%0d data", c, u), od[u], vexp ? vm[u] : 32'd0);
                chk($sformatf("rnd%0d u%0d busy", c, u), 32'(bz[u]), 32'(bm[u]));
                pend_acc[u] = iv[u] && irexp;
                pend_pop[u] = vexp && ordy[u];
                pend_val[u] = (u == 0) ? xor_sh({32'h0, sh2}, 2) : xor_sh(sh3, 3);
            end
            @(posedge clk);
            cyc++;
            for (int u = 0; u < 2; u++) begin
                if (fl[u]) begin
                    bm[u] = 1'b0;
                end else begin
                    if (pend_pop[u]) bm[u] = 1'b0;
                    if (pend_acc[u]) begin
                        bm[u]  = 1'b1;
                        vm[u]  = pend_val[u];
                        rdy[u] = cyc + ((u == 0) ? 2 : 3);
                    end
                end
            end
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
